ravenoc_out_arbiter: RTL and testbench

Wormhole round-robin arbiter for one router output port (N/S/W/E/local). It picks one input port whose head flit targets this output and locks the output to that port until the packet's tail flit is accepted. It drives the select for the output flit mux and the grant back to the input buffers. One instance per output port inside each router of the mesh.

---
 rtl/ravenoc_out_arbiter_if.sv | 36 +++
 rtl/ravenoc_out_arbiter.sv | 157 +++++++++++++++
 tb/tb_ravenoc_out_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ravenoc_out_arbiter_if.sv
// ----------------------------------------------------------------------------
// ravenoc_out_arbiter_if
// Handshake bundle between the input buffers / output mux and one output-port
// arbiter.
//   req_valid_i : per-port flit present and routed to this output
//   req_head_i  : per-port presented flit is a head
//   req_tail_i  : per-port presented flit is a tail (head+tail = single flit)
//   out_ready_i : downstream accepts a flit this cycle
//   grant_o     : one-hot grant back to the input buffers
//   sel_o       : granted port index for the output flit mux
//   out_valid_o : a granted flit is present on the output
// Modports: slave = arbiter side, master = buffer/mux side.
// ----------------------------------------------------------------------------
interface ravenoc_out_arbiter_if #(
    parameter int unsigned N_PORTS = 5
);
    localparam int unsigned SelW = $clog2(N_PORTS);

    logic [N_PORTS-1:0] req_valid_i;
    logic [N_PORTS-1:0] req_head_i;
    logic [N_PORTS-1:0] req_tail_i;
    logic               out_ready_i;
    logic [N_PORTS-1:0] grant_o;
    logic [SelW-1:0]    sel_o;
    logic               out_valid_o;

    modport slave (
        input  req_valid_i, req_head_i, req_tail_i, out_ready_i,
        output grant_o, sel_o, out_valid_o
    );

    modport master (
        output req_valid_i, req_head_i, req_tail_i, out_ready_i,
        input  grant_o, sel_o, out_valid_o
    );
endinterface

// File: rtl/ravenoc_out_arbiter.sv
// ----------------------------------------------------------------------------
// ravenoc_out_arbiter
// Wormhole round-robin arbiter for one router output port. Picks an input
// whose head flit targets this output and holds the output for that input
// until its tail flit is accepted.
// Ports:
//   clk_noc    : NoC clock
//   arst_noc   : synchronous active-high reset
//   arb_if     : request/grant handshake bundle (slave modport)
//   locked_o   : high while the output is locked to a packet
//   wdog_err_o : sticky stall-watchdog error
// Optional feature: define RAVENOC_ARB_WDOG_EN to enable the stall watchdog
// (WDOG_CYCLES stalled locked cycles force the lock to drop). Without it the
// lock lasts indefinitely and wdog_err_o is tied 0.
// ----------------------------------------------------------------------------
module ravenoc_out_arbiter #(
    parameter int unsigned N_PORTS     = 5,
    parameter int unsigned WDOG_CYCLES = 256
) (
    input  logic                 clk_noc,
    input  logic                 arst_noc,
    ravenoc_out_arbiter_if.slave arb_if,
    output logic                 locked_o,
    output logic                 wdog_err_o
);
    localparam int unsigned SelW = $clog2(N_PORTS);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e             r_state, w_state_nxt;
    logic [SelW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [SelW-1:0]    r_lock_idx, w_lock_idx_nxt;

    logic [N_PORTS-1:0] w_cand;
    logic [SelW-1:0]    w_idx;
    logic [SelW-1:0]    w_winner;
    logic               w_found;
    logic [N_PORTS-1:0] w_grant;
    logic [SelW-1:0]    w_sel;
    logic               w_fire;
    logic               w_tail_sel;
    logic               w_wdog_trip;

    // Increment modulo N_PORTS; N_PORTS need not be a power of two.
    function automatic logic [SelW-1:0] f_inc(input logic [SelW-1:0] idx);
        if (32'(idx) == N_PORTS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    assign w_cand = arb_if.req_valid_i & arb_if.req_head_i;

    // First head candidate at or above rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_idx    = r_rr_ptr;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
            w_idx = f_inc(w_idx);
        end
    end

    always_comb begin
        w_grant = '0;
        w_sel   = r_rr_ptr;
        if (r_state == StLocked) begin
            w_grant[r_lock_idx] = 1'b1;
            w_sel               = r_lock_idx;
        end else if (w_found) begin
            w_grant[w_winner] = 1'b1;
            w_sel             = w_winner;
        end
    end

    assign w_tail_sel = arb_if.req_tail_i[w_sel];
    assign w_fire     = (|(w_grant & arb_if.req_valid_i)) & arb_if.out_ready_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_idx_nxt = r_lock_idx;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    if (w_fire && w_tail_sel) begin
                        w_rr_ptr_nxt = f_inc(w_winner);
                    end else begin
                        // Unaccepted heads lock too, keeping the grant stable.
                        w_state_nxt    = StLocked;
                        w_lock_idx_nxt = w_winner;
                    end
                end
            end
            StLocked: begin
                if ((w_fire && w_tail_sel) || w_wdog_trip) begin
                    w_state_nxt  = StIdle;
                    w_rr_ptr_nxt = f_inc(r_lock_idx);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            r_state    <= StIdle;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

`ifdef RAVENOC_ARB_WDOG_EN
    logic [15:0] r_wdog_cnt, w_wdog_cnt_nxt;
    logic        r_wdog_err;

    assign w_wdog_trip = (r_state == StLocked) && !w_fire &&
                         (r_wdog_cnt == 16'(WDOG_CYCLES - 1));

    always_comb begin
        w_wdog_cnt_nxt = r_wdog_cnt + 16'd1;
        if ((r_state != StLocked) || w_fire || w_wdog_trip) begin
            w_wdog_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            if (w_wdog_trip) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err_o = r_wdog_err;
`else
    assign w_wdog_trip = 1'b0;
    assign wdog_err_o  = 1'b0;
`endif

    assign arb_if.grant_o     = w_grant;
    assign arb_if.sel_o       = w_sel;
    assign arb_if.out_valid_o = |(w_grant & arb_if.req_valid_i);
    assign locked_o           = (r_state == StLocked);
endmodule

// File: tb/tb_ravenoc_out_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ravenoc_out_arbiter
// Drives directed and random flit requests; a reference model predicts each
// cycle's outputs into a queue that a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_ravenoc_out_arbiter;
    localparam int NP   = 5;
    localparam int WDOG = 8;

    typedef struct {
        bit          chk;
        logic [4:0]  grant;
        logic [2:0]  sel;
        bit          ov;
        bit          lk;
        bit          err;
    } exp_t;

    logic clk;
    logic arst;
    logic locked;
    logic wdog_err;

    ravenoc_out_arbiter_if #(.N_PORTS(NP)) arb_if ();

    ravenoc_out_arbiter #(
        .N_PORTS    (NP),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk_noc   (clk),
        .arst_noc  (arst),
        .arb_if    (arb_if),
        .locked_o  (locked),
        .wdog_err_o(wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: owner = locked port or -1, rr = next port to favour.
    int   m_owner = -1;
    int   m_rr    = 0;
    int   m_stall = 0;
    bit   m_err   = 1'b0;
    bit   m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                chk("grant",     32'(arb_if.grant_o),     32'(mon_e.grant));
                chk("sel",       32'(arb_if.sel_o),       32'(mon_e.sel));
                chk("out_valid", 32'(arb_if.out_valid_o), 32'(mon_e.ov));
                chk("locked",    32'(locked),             32'(mon_e.lk));
                chk("wdog_err",  32'(wdog_err),           32'(mon_e.err));
            end
        end
    end

    task automatic step(input logic [NP-1:0] v, input logic [NP-1:0] h,
                        input logic [NP-1:0] t, input logic rdy, input logic rst);
        exp_t           e;
        int             win;
        int             own_now;
        logic [NP-1:0]  g;
        bit             fire;
        @(posedge clk);
        #1;
        arb_if.req_valid_i = v;
        arb_if.req_head_i  = h;
        arb_if.req_tail_i  = t;
        arb_if.out_ready_i = rdy;
        arst               = rst;

        win = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_rr + k) % NP;
                if (win < 0 && v[p] && h[p]) win = p;
            end
        end
        own_now = (m_owner >= 0) ? m_owner : win;
        g = '0;
        if (own_now >= 0) g[own_now] = 1'b1;
        e.chk   = m_known;
        e.grant = g;
        e.sel   = 3'((own_now >= 0) ? own_now : m_rr);
        e.ov    = |(g & v);
        e.lk    = (m_owner >= 0);
        e.err   = m_err;
        sb.push_back(e);

        fire = e.ov && rdy;
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_stall = 0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_owner < 0) begin
                if (win >= 0) begin
                    if (fire && t[win]) m_rr = (win + 1) % NP;
                    else m_owner = win;
                end
            end else if (fire) begin
                m_stall = 0;
                if (t[m_owner]) begin
                    m_rr    = (m_owner + 1) % NP;
                    m_owner = -1;
                end
            end else begin
`ifdef RAVENOC_ARB_WDOG_EN
                m_stall++;
                if (m_stall == WDOG) begin
                    m_err   = 1'b1;
                    m_rr    = (m_owner + 1) % NP;
                    m_owner = -1;
                    m_stall = 0;
                end
`endif
            end
        end
    endtask

    initial begin
        logic [NP-1:0] v, h, t;
        arst = 1'b1;
        arb_if.req_valid_i = '0;
        arb_if.req_head_i  = '0;
        arb_if.req_tail_i  = '0;
        arb_if.out_ready_i = 1'b0;

        // Reset, then idle with all inputs low.
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);

        // Round robin over single-flit packets on ports 0, 2, 4.
        repeat (6) step(5'b10101, 5'b10101, 5'b10101, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);

        // Wormhole: port 1 four-flit packet while port 3 waits with a head.
        step(5'b01010, 5'b01010, 5'b00000, 1'b1, 1'b0);
        step(5'b01010, 5'b01000, 5'b00000, 1'b1, 1'b0);
        step(5'b01010, 5'b01000, 5'b00000, 1'b1, 1'b0);
        step(5'b01010, 5'b01000, 5'b00010, 1'b1, 1'b0);
        step(5'b01000, 5'b01000, 5'b01000, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);

        // Backpressure: port 2 head stalls, port 0 head arrives meanwhile.
        step(5'b00100, 5'b00100, 5'b00000, 1'b0, 1'b0);
        step(5'b00101, 5'b00101, 5'b00000, 1'b0, 1'b0);
        step(5'b00101, 5'b00101, 5'b00000, 1'b0, 1'b0);
        step(5'b00101, 5'b00101, 5'b00000, 1'b1, 1'b0);
        step(5'b00101, 5'b00001, 5'b00100, 1'b1, 1'b0);
        step(5'b00001, 5'b00001, 5'b00001, 1'b1, 1'b0);

        // Valid body flit without a head is never granted in idle.
        step(5'b10000, 5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b10000, 5'b00000, 5'b10000, 1'b1, 1'b0);

        // Watchdog: port 0 head accepted, then the packet stalls.
        step(5'b00001, 5'b00001, 5'b00000, 1'b1, 1'b0);
        repeat (12) step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b0, 1'b1);

        // Random traffic with occasional resets, including mid-packet.
        repeat (3000) begin
            for (int p = 0; p < NP; p++) begin
                v[p] = ($urandom_range(0, 9) < 6);
                h[p] = ($urandom_range(0, 9) < 4);
                t[p] = ($urandom_range(0, 9) < 4);
            end
            step(v, h, t, ($urandom_range(0, 9) < 7), ($urandom_range(0, 299) == 0));
        end

        step('0, '0, '0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
